fp_mult_seq: RTL and testbench

Sequential IEEE-754 single-precision multiplier that produces the 32-bit `FinalProduct` word consumed by the downstream one-cycle product register stage of the HCORDIC datapath. It accepts two operands on a `start` pulse and computes the 24×24 mantissa product by iterative shift-add. It normalises, rounds to nearest-even and presents the packed result with a one-cycle `done` strobe. Latency is fixed and data-independent, so the pipeline controller can schedule the downstream stage statically.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_mult_seq_mant.sv | 50 +++++
 rtl/fp_mult_seq.sv | 147 ++++++++++++++
 tb/tb_fp_mult_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential single-precision multiplier.
//   FP_BIAS / FP_EXP_MAX / FP_QNAN : IEEE-754 single constants
//   state_t                        : controller states
//   cls_t                          : special-operand classes
//   classify()                     : folds two operands into one result class
package fp_pkg;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;
  typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  // Denormals (exp==0) count as zero. Inf x 0 is invalid and yields NaN.
  function automatic cls_t classify(input logic [31:0] a, input logic [31:0] b);
    logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    zero_a = (a[30:23] == 8'h00);
    zero_b = (b[30:23] == 8'h00);
    inf_a  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    inf_b  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) return CLS_NAN;
    if (inf_a || inf_b)   return CLS_INF;
    if (zero_a || zero_b) return CLS_ZERO;
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/fp_mult_seq_mant.sv
// 24x24 unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
//   clock, reset : clock, async active-low reset
//   load         : capture a/b, clear accumulator, start a 24-step run
//   a, b         : multiplicand, multiplier
//   p            : accumulator; holds the full product once the run ends
//   last         : high during the final (24th) step
module mant_mult_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] p,
  output logic        last
);

  logic [47:0] mcand;
  logic [23:0] mplier;
  logic [47:0] acc;
  logic [4:0]  cnt;
  logic        run;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (load) begin
      mcand  <= {24'h0, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      // The multiplicand walks left so each step adds it at the weight of
      // the multiplier bit currently sitting in mplier[0].
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
      if (cnt == 5'd23) run <= 1'b0;
    end
  end

  assign p    = acc;
  assign last = run && (cnt == 5'd23);

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754 single-precision multiplier with fixed 27-cycle latency.
//   clock, reset     : clock, async active-low reset
//   start            : operand-valid pulse, accepted only in IDLE
//   InputX, InputY   : operands
//   busy             : operation in flight (UNPACK through DONE)
//   done             : one-cycle strobe, FinalProduct newly updated
//   FinalProduct     : packed product, held until the next done
//   dbg_state        : current controller state
//
// Handshake: start is a request sampled on a rising edge only while busy is
// low; there is no back-pressure and no queueing, so a start seen while busy
// is dropped. busy rises the cycle after acceptance and falls together with
// done; done is high for exactly one cycle, 27 edges after acceptance.
module fp_mult_seq
  import fp_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] InputX,
  input  logic [31:0] InputY,
  output logic        busy,
  output logic        done,
  output logic [31:0] FinalProduct,
  output state_t      dbg_state
);

  localparam logic signed [9:0] BIAS10 = 10'(FP_BIAS);

  state_t             state, state_nxt;
  logic [31:0]        op_a, op_b;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  cls_t               cls_r;
  logic [46:0]        norm_m;

  logic [23:0]        mant_a, mant_b;
  logic               mult_load, mult_last;
  logic [47:0]        mult_p;

  // Denormal operands feed a zero mantissa; their class already forces zero.
  assign mant_a = (op_a[30:23] == 8'h00) ? 24'h0 : {1'b1, op_a[22:0]};
  assign mant_b = (op_b[30:23] == 8'h00) ? 24'h0 : {1'b1, op_b[22:0]};

  mant_mult_seq u_mant (
    .clock (clock),
    .reset (reset),
    .load  (mult_load),
    .a     (mant_a),
    .b     (mant_b),
    .p     (mult_p),
    .last  (mult_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mult_load = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = UNPACK;
      UNPACK: begin
        mult_load = 1'b1;
        state_nxt = MULT;
      end
      MULT:   if (mult_last) state_nxt = NORM;
      NORM:   state_nxt = ROUND;
      ROUND:  state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  // Rounding: after NORM the leading one sits at bit 46.
  logic [23:0]       m24;
  logic              guard_b, round_b, sticky_b, round_up;
  logic [24:0]       m25;
  logic signed [9:0] exp_fin;
  logic [22:0]       frac;
  logic [31:0]       packed_res;

  always_comb begin
    m24      = norm_m[46:23];
    guard_b  = norm_m[22];
    round_b  = norm_m[21];
    sticky_b = |norm_m[20:0];
    round_up = guard_b & (round_b | sticky_b | m24[0]);
    m25      = {1'b0, m24} + {24'h0, round_up};
    // Carry-out means the mantissa rolled over to 2.0: renormalise.
    exp_fin  = exp_r + 10'(m25[24]);
    frac     = m25[24] ? m25[23:1] : m25[22:0];
    packed_res = {sign_r, exp_fin[7:0], frac};
    case (cls_r)
      CLS_NAN:  packed_res = FP_QNAN;
      CLS_INF:  packed_res = {sign_r, 8'hFF, 23'h0};
      CLS_ZERO: packed_res = {sign_r, 31'h0};
      default: begin
        if (exp_fin >= FP_EXP_MAX)  packed_res = {sign_r, 8'hFF, 23'h0};
        else if (exp_fin <= 0)      packed_res = {sign_r, 31'h0};
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_a         <= '0;
      op_b         <= '0;
      sign_r       <= 1'b0;
      exp_r        <= '0;
      cls_r        <= CLS_NORMAL;
      norm_m       <= '0;
      FinalProduct <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a <= InputX;
          op_b <= InputY;
        end
        UNPACK: begin
          sign_r <= op_a[31] ^ op_b[31];
          exp_r  <= $signed({2'b00, op_a[30:23]}) + $signed({2'b00, op_b[30:23]}) - BIAS10;
          cls_r  <= classify(op_a, op_b);
        end
        NORM: begin
          // Product in [2,4): shift right once, folding the dropped bit
          // into the lowest (sticky) position so rounding still sees it.
          if (mult_p[47]) begin
            norm_m <= {mult_p[47:2], |mult_p[1:0]};
            exp_r  <= exp_r + 10'sd1;
          end else begin
            norm_m <= mult_p[46:0];
          end
        end
        ROUND: FinalProduct <= packed_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Self-checking bench for fp_mult_seq: directed vectors, start-while-busy,
// back-to-back throughput, mid-operation reset and randomized operands
// against an integer reference model of IEEE-754 single multiplication.
module tb_fp_mult_seq;
  import fp_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] InputX, InputY;
  logic        busy, done;
  logic [31:0] FinalProduct;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fp_mult_seq dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .InputX       (InputX),
    .InputY       (InputY),
    .busy         (busy),
    .done         (done),
    .FinalProduct (FinalProduct),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ea, eb, e, sh;
    bit s, zx, zy, ix, iy, nx, ny;
    longint unsigned ma, mb, p, q, rem, half;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    s  = x[31] ^ y[31];
    zx = (ea == 0);
    zy = (eb == 0);
    ix = (ea == 255) && (x[22:0] == 0);
    iy = (eb == 255) && (y[22:0] == 0);
    nx = (ea == 255) && (x[22:0] != 0);
    ny = (eb == 255) && (y[22:0] != 0);
    if (nx || ny || (ix && zy) || (iy && zx)) return 32'h7FC0_0000;
    if (ix || iy) return {s, 8'hFF, 23'h0};
    if (zx || zy) return {s, 31'h0};
    ma = {40'h0, 1'b1, x[22:0]};
    mb = {40'h0, 1'b1, y[22:0]};
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], q[22:0]};
  endfunction

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; start is sampled on the very next rising edge.
  // poke re-raises start at edges k+5 and k+27, both of which must be ignored.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input bit poke,
                       output logic [31:0] res);
    int lat, busy_n;
    logic [31:0] expv;
    exp_q.push_back(ref_mul(x, y));
    start  = 1'b1;
    InputX = x;
    InputY = y;
    @(negedge clock);
    start  = 1'b0;
    InputX = $urandom;
    InputY = $urandom;
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (poke && (lat == 4 || lat == 26)) begin
        start  = 1'b1;
        InputX = $urandom;
        InputY = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    res   = FinalProduct;
    chk("latency", 32'(lat), 32'd27);
    chk("busy_cycles", 32'(busy_n), 32'd27);
    chk("busy_at_done", {31'h0, busy}, 32'd1);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk("product", res, expv);
    @(negedge clock);
    chk("done_drop", {31'h0, done}, 32'd0);
    chk("busy_drop", {31'h0, busy}, 32'd0);
    chk("product_hold", FinalProduct, res);
  endtask

  // ---------------- directed vectors ----------------
  logic [31:0] dir_x[8] = '{32'h4000_0000, 32'hBFC0_0000, 32'h3F80_0001, 32'h7F80_0000,
                            32'hFF80_0000, 32'h0040_0000, 32'h7F00_0000, 32'h0080_0000};
  logic [31:0] dir_y[8] = '{32'h4040_0000, 32'h3FC0_0000, 32'h3F80_0001, 32'h0000_0000,
                            32'h4000_0000, 32'h4000_0000, 32'h7F00_0000, 32'h0080_0000};
  logic [31:0] dir_z[8] = '{32'h40C0_0000, 32'hC010_0000, 32'h3F80_0002, 32'h7FC0_0000,
                            32'hFF80_0000, 32'h0000_0000, 32'h7F80_0000, 32'h0000_0000};

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] res;
    logic [31:0] rx, ry;
    int done_n;

    reset  = 1'b0;
    start  = 1'b0;
    InputX = '0;
    InputY = '0;
    repeat (2) @(negedge clock);
    chk("reset_busy", {31'h0, busy}, 32'd0);
    chk("reset_done", {31'h0, done}, 32'd0);
    chk("reset_product", FinalProduct, 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;
    @(negedge clock);

    // Directed vectors, issued back to back at the minimum 29-cycle spacing.
    for (int i = 0; i < 8; i++) begin
      do_op(dir_x[i], dir_y[i], 1'b0, res);
      chk("directed", res, dir_z[i]);
    end

    // start while busy and in the ROUND->DONE cycle: exactly one done.
    do_op(32'h4000_0000, 32'h4040_0000, 1'b1, res);
    chk("poke_product", res, 32'h40C0_0000);
    done_n = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) done_n++;
      @(negedge clock);
    end
    chk("poke_no_extra", 32'(done_n), 32'd0);

    // Reset in the middle of MULT.
    start  = 1'b1;
    InputX = 32'h4040_0000;
    InputY = 32'h4040_0000;
    @(negedge clock);
    start = 1'b0;
    repeat (11) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_product", FinalProduct, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_op(32'h3FC0_0000, 32'h4000_0000, 1'b0, res);
    chk("after_abort", res, 32'h4040_0000);

    // Randomized operands: moderate exponents reach both overflow and underflow.
    for (int i = 0; i < 24; i++) begin
      rx = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 194)), 23'($urandom)};
      ry = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 194)), 23'($urandom)};
      if (i % 8 == 7) ry = $urandom;
      do_op(rx, ry, 1'b0, res);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
